// File: rtl/sd_sector_responder_pkg.sv
// sd_sector_responder_pkg: shared FSM states and sector constants for the SD sector responder.
package sd_sector_responder_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ACK_WAIT,
        RD_REQ,
        RD_WAIT,
        RD_PUT,
        WR_ADDR,
        WR_REQ,
        WR_WAIT,
        DONE
    } state_t;

    localparam int SECTOR_WORDS  = 256;
    localparam int ACK_DELAY_MAX = 15;

endpackage

// File: rtl/sd_sector_responder.sv
// sd_sector_responder: serves 256-word sector reads/writes from an SD-style initiator
// against a word-addressed image memory with handshaked (mem_rdy) completion.
module sd_sector_responder
    import sd_sector_responder_pkg::*;
#(
    parameter int LBA_BITS  = 4,
    parameter int ACK_DELAY = 2
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic [31:0]         sd_lba,
    input  logic                sd_rd,
    input  logic                sd_wr,
    output logic                sd_ack,
    output logic [7:0]          sd_buff_addr,
    output logic [15:0]         sd_buff_dout,
    output logic                sd_buff_wr,
    input  logic [15:0]         sd_buff_din,
    output logic [LBA_BITS+7:0] mem_addr,
    output logic                mem_rd,
    output logic                mem_wr,
    output logic [15:0]         mem_din,
    input  logic [15:0]         mem_dout,
    input  logic                mem_rdy,
    output logic                lba_err
);

    localparam int ACK_DLY = (ACK_DELAY > ACK_DELAY_MAX) ? ACK_DELAY_MAX : ACK_DELAY;

    state_t                state_q;
    logic [LBA_BITS-1:0]   lba_q;
    logic                  rd_q;
    logic                  oor_q;
    logic                  armed_q;
    logic [3:0]            cnt_q;
    logic [8:0]            word_q;
    logic                  sd_ack_q;
    logic [7:0]            sd_buff_addr_q;
    logic [15:0]           sd_buff_dout_q;
    logic                  sd_buff_wr_q;
    logic [LBA_BITS+7:0]   mem_addr_q;
    logic                  mem_rd_q;
    logic                  mem_wr_q;
    logic [15:0]           mem_din_q;
    logic                  lba_err_q;

    logic req;
    logic oor;
    logic last;
    logic ack_go;

    assign req    = sd_rd | sd_wr;
    assign oor    = (sd_lba >> LBA_BITS) != 32'd0;
    assign last   = word_q == 9'(SECTOR_WORDS - 1);
    assign ack_go = ({1'b0, cnt_q} + 5'd1) >= 5'(ACK_DLY);

    // Pulse outputs default low each cycle; states that need them re-assert.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            lba_q          <= '0;
            rd_q           <= 1'b0;
            oor_q          <= 1'b0;
            armed_q        <= 1'b0;
            cnt_q          <= '0;
            word_q         <= '0;
            sd_ack_q       <= 1'b0;
            sd_buff_addr_q <= '0;
            sd_buff_dout_q <= '0;
            sd_buff_wr_q   <= 1'b0;
            mem_addr_q     <= '0;
            mem_rd_q       <= 1'b0;
            mem_wr_q       <= 1'b0;
            mem_din_q      <= '0;
            lba_err_q      <= 1'b0;
        end else begin
            sd_buff_wr_q <= 1'b0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            if (!req) armed_q <= 1'b1;
            case (state_q)
                IDLE: if (req && armed_q) begin
                    armed_q   <= 1'b0;
                    lba_q     <= sd_lba[LBA_BITS-1:0];
                    rd_q      <= sd_rd;
                    oor_q     <= oor;
                    lba_err_q <= oor;
                    cnt_q     <= '0;
                    state_q   <= ACK_WAIT;
                end
                ACK_WAIT: if (ack_go) begin
                    sd_ack_q       <= 1'b1;
                    word_q         <= '0;
                    cnt_q          <= '0;
                    sd_buff_addr_q <= '0;
                    state_q        <= rd_q ? RD_REQ : WR_ADDR;
                end else begin
                    cnt_q <= cnt_q + 4'd1;
                end
                RD_REQ: begin
                    mem_rd_q   <= !oor_q;
                    mem_addr_q <= {lba_q, word_q[7:0]};
                    state_q    <= RD_WAIT;
                end
                RD_WAIT: if (oor_q || mem_rdy) begin
                    sd_buff_dout_q <= oor_q ? 16'h0000 : mem_dout;
                    state_q        <= RD_PUT;
                end
                RD_PUT: begin
                    sd_buff_wr_q   <= 1'b1;
                    sd_buff_addr_q <= word_q[7:0];
                    word_q         <= word_q + 9'd1;
                    state_q        <= last ? DONE : RD_REQ;
                end
                // The initiator's buffer RAM is registered, so its data lags the address by one cycle.
                WR_ADDR: state_q <= WR_REQ;
                WR_REQ: begin
                    mem_din_q  <= sd_buff_din;
                    mem_wr_q   <= !oor_q;
                    mem_addr_q <= {lba_q, word_q[7:0]};
                    state_q    <= WR_WAIT;
                end
                WR_WAIT: if (oor_q || mem_rdy) begin
                    word_q <= word_q + 9'd1;
                    if (last) begin
                        state_q <= DONE;
                    end else begin
                        sd_buff_addr_q <= word_q[7:0] + 8'd1;
                        state_q        <= WR_ADDR;
                    end
                end
                DONE: begin
                    sd_ack_q       <= 1'b0;
                    sd_buff_addr_q <= '0;
                    word_q         <= '0;
                    state_q        <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sd_ack       = sd_ack_q;
    assign sd_buff_addr = sd_buff_addr_q;
    assign sd_buff_dout = sd_buff_dout_q;
    assign sd_buff_wr   = sd_buff_wr_q;
    assign mem_addr     = mem_addr_q;
    assign mem_rd       = mem_rd_q;
    assign mem_wr       = mem_wr_q;
    assign mem_din      = mem_din_q;
    assign lba_err      = lba_err_q;

endmodule

// File: tb/tb_sd_sector_responder.sv
// tb_sd_sector_responder: scoreboard bench; expected strobes/memory writes are queued at
// request time and popped by a monitor whenever the DUT presents sd_buff_wr or mem_wr.
module tb_sd_sector_responder;

    localparam int LB = 4;

    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b0;
    logic [31:0]   sd_lba = '0;
    logic          sd_rd = 1'b0;
    logic          sd_wr = 1'b0;
    logic          sd_ack;
    logic [7:0]    sd_buff_addr;
    logic [15:0]   sd_buff_dout;
    logic          sd_buff_wr;
    logic [15:0]   sd_buff_din = '0;
    logic [LB+7:0] mem_addr;
    logic          mem_rd;
    logic          mem_wr;
    logic [15:0]   mem_din;
    logic [15:0]   mem_dout = '0;
    logic          mem_rdy = 1'b0;
    logic          lba_err;

    int passed = 0;
    int total = 0;
    int strobes = 0;
    int mrds = 0;
    int mwrs = 0;
    int lat_min = 1;
    int lat_max = 1;

    logic [23:0] sq[$];
    logic [27:0] wq[$];

    always #5 clk_sys = ~clk_sys;

    sd_sector_responder #(.LBA_BITS(LB), .ACK_DELAY(2)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
        .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din), .mem_addr(mem_addr),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_rdy(mem_rdy), .lba_err(lba_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Image memory: word at address a reads as a ^ A5A5, completion after lat_min..lat_max cycles.
    initial begin
        int n;
        logic [15:0] d;
        forever begin
            @(negedge clk_sys);
            if (reset_n && (mem_rd || mem_wr)) begin
                d = 16'(mem_addr) ^ 16'hA5A5;
                n = $urandom_range(lat_max, lat_min);
                @(posedge clk_sys);
                repeat (n - 1) @(posedge clk_sys);
                #1 mem_rdy = 1'b1;
                mem_dout = d;
                @(posedge clk_sys);
                #1 mem_rdy = 1'b0;
            end
        end
    end

    // Initiator buffer RAM with registered output holding 16'h1000 + index.
    initial begin
        logic [7:0] da;
        forever begin
            @(negedge clk_sys);
            da = sd_buff_addr;
            @(posedge clk_sys);
            #1 sd_buff_din = 16'h1000 + 16'(da);
        end
    end

    initial begin
        forever begin
            @(negedge clk_sys);
            if (reset_n) begin
                if (sd_buff_wr) begin
                    strobes++;
                    chk("strobe_in_ack", 32'(sd_ack), 32'd1);
                    chk("strobe_expected", 32'(sq.size() != 0), 32'd1);
                    if (sq.size() != 0) chk("strobe_data", {8'h0, sd_buff_addr, sd_buff_dout}, {8'h0, sq.pop_front()});
                end
                if (mem_rd) mrds++;
                if (mem_wr) begin
                    mwrs++;
                    chk("memwr_expected", 32'(wq.size() != 0), 32'd1);
                    if (wq.size() != 0) chk("memwr_data", {4'h0, mem_addr, mem_din}, {4'h0, wq.pop_front()});
                end
                if (mem_rd || mem_wr) chk("rd_wr_exclusive", 32'(mem_rd && mem_wr), 32'd0);
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: run did not finish, %0d/%0d checks passed", passed, total);
        $fatal(1);
    end

    task automatic push_read(input logic [31:0] lba, input bit bad);
        for (int i = 0; i < 256; i++)
            sq.push_back({8'(i), bad ? 16'h0000 : (16'(lba << 8) | 16'(i)) ^ 16'hA5A5});
    endtask

    task automatic do_req(input logic rd, input logic wr, input logic [31:0] lba, input bit hold,
                          output int ack_edges);
        int n;
        @(posedge clk_sys);
        #1 sd_lba = lba;
        sd_rd = rd;
        sd_wr = wr;
        ack_edges = 0;
        while (!sd_ack && ack_edges < 40) begin
            @(posedge clk_sys);
            #1 ack_edges++;
        end
        chk("ack_rise", 32'(sd_ack), 32'd1);
        if (!hold) begin
            sd_rd = 1'b0;
            sd_wr = 1'b0;
        end
        n = 0;
        while (sd_ack && n < 8000) begin
            @(posedge clk_sys);
            #1 n++;
        end
        chk("ack_fall", 32'(sd_ack), 32'd0);
        if (hold) begin
            repeat (12) @(posedge clk_sys);
            #1 chk("no_retrigger", 32'(sd_ack), 32'd0);
            sd_rd = 1'b0;
            sd_wr = 1'b0;
        end
        repeat (2) @(posedge clk_sys);
    endtask

    initial begin
        int e;
        int n;
        int s0;
        repeat (2) @(posedge clk_sys);
        #1 chk("reset_state", {27'h0, sd_ack, sd_buff_wr, mem_rd, mem_wr, lba_err}, 32'd0);
        reset_n = 1'b1;
        repeat (3) @(posedge clk_sys);

        // Read lba 3, latency 1; ack expected on the second edge after the detecting edge.
        push_read(32'd3, 1'b0);
        strobes = 0; mrds = 0; mwrs = 0;
        do_req(1'b1, 1'b0, 32'd3, 1'b0, e);
        chk("ack_latency", 32'(e), 32'd3);
        chk("read_strobes", 32'(strobes), 32'd256);
        chk("read_memrd", 32'(mrds), 32'd256);
        chk("read_lba_err", 32'(lba_err), 32'd0);
        chk("read_sq_drained", 32'(sq.size()), 32'd0);

        // Write lba 1.
        for (int i = 0; i < 256; i++) wq.push_back({12'h100 + 12'(i), 16'h1000 + 16'(i)});
        strobes = 0; mrds = 0; mwrs = 0;
        do_req(1'b0, 1'b1, 32'd1, 1'b0, e);
        chk("write_memwr", 32'(mwrs), 32'd256);
        chk("write_strobes", 32'(strobes), 32'd0);
        chk("write_memrd", 32'(mrds), 32'd0);
        chk("write_wq_drained", 32'(wq.size()), 32'd0);

        // Both requests at lba 0, held through the transfer: read wins, no retrigger.
        push_read(32'd0, 1'b0);
        strobes = 0; mrds = 0; mwrs = 0;
        do_req(1'b1, 1'b1, 32'd0, 1'b1, e);
        chk("both_strobes", 32'(strobes), 32'd256);
        chk("both_memwr", 32'(mwrs), 32'd0);

        // Out-of-range read lba 16.
        push_read(32'd16, 1'b1);
        strobes = 0; mrds = 0; mwrs = 0;
        do_req(1'b1, 1'b0, 32'd16, 1'b0, e);
        chk("oor_read_err", 32'(lba_err), 32'd1);
        chk("oor_read_strobes", 32'(strobes), 32'd256);
        chk("oor_read_memrd", 32'(mrds), 32'd0);

        // Out-of-range write, top bit only.
        strobes = 0; mrds = 0; mwrs = 0;
        do_req(1'b0, 1'b1, 32'h8000_0001, 1'b0, e);
        chk("oor_write_err", 32'(lba_err), 32'd1);
        chk("oor_write_memwr", 32'(mwrs), 32'd0);
        chk("oor_write_strobes", 32'(strobes), 32'd0);

        // Reset at word 100 of an in-range read.
        push_read(32'd2, 1'b0);
        strobes = 0;
        @(posedge clk_sys);
        #1 sd_lba = 32'd2;
        sd_rd = 1'b1;
        n = 0;
        while (!sd_ack && n < 40) begin
            @(posedge clk_sys);
            #1 n++;
        end
        sd_rd = 1'b0;
        chk("err_cleared", 32'(lba_err), 32'd0);
        n = 0;
        while (strobes < 100 && n < 4000) begin
            @(posedge clk_sys);
            #1 n++;
        end
        chk("reached_word100", 32'(strobes), 32'd100);
        reset_n = 1'b0;
        #1;
        chk("rst_ctrl", {27'h0, sd_ack, sd_buff_wr, mem_rd, mem_wr, lba_err}, 32'd0);
        chk("rst_buff", {8'h0, sd_buff_addr, sd_buff_dout}, 32'd0);
        chk("rst_mem", {4'h0, mem_addr, mem_din}, 32'd0);
        sq.delete();
        s0 = strobes;
        repeat (3) @(posedge clk_sys);
        #1 reset_n = 1'b1;
        repeat (60) @(posedge clk_sys);
        #1 chk("no_strobe_after_rst", 32'(strobes), 32'(s0));
        chk("no_ack_after_rst", 32'(sd_ack), 32'd0);

        // Four back-to-back sectors with random latency 1..20, top sector included.
        lat_min = 1; lat_max = 20;
        strobes = 0; mrds = 0; mwrs = 0;
        foreach (sq[i]) sq.delete(i);
        push_read(32'd5, 1'b0);  do_req(1'b1, 1'b0, 32'd5, 1'b0, e);
        push_read(32'd6, 1'b0);  do_req(1'b1, 1'b0, 32'd6, 1'b0, e);
        push_read(32'd7, 1'b0);  do_req(1'b1, 1'b0, 32'd7, 1'b0, e);
        push_read(32'd15, 1'b0); do_req(1'b1, 1'b0, 32'd15, 1'b0, e);
        chk("b2b_strobes", 32'(strobes), 32'd1024);
        chk("b2b_memrd", 32'(mrds), 32'd1024);
        chk("b2b_sq_drained", 32'(sq.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
